// File: rtl/axis_rr_arbiter_if.sv
// ============================================================================
// Module   : axis_if
// Brief    : AXI Stream handshake bundle (tvalid/tready/tdata) with modports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axis_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
// Module   : axis_rr_arbiter
// Brief    : N:1 round-robin AXI Stream arbiter with a registered output stage
//            carrying data and source ID. Define AXIS_RR_ARB_FIXED_PRIO_EN for
//            fixed lowest-index-wins priority instead of round-robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter #(
  parameter  int NUM_REQ  = 2,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic                clk,
  input  wire logic                rst,
  axis_if.slave                    axis_sif [NUM_REQ],
  axis_if.master                   axis_mif,
  output logic      [ID_WIDTH-1:0] m_tid,
  input  wire logic                invalidate
);

  localparam int TDATA_WIDTH = $bits(axis_mif.tdata);

  logic [NUM_REQ-1:0]     w_valid;
  logic [NUM_REQ-1:0]     w_ready;
  logic [TDATA_WIDTH-1:0] w_data [NUM_REQ];

  logic                   w_any;
  logic                   w_out_free;
  logic                   w_take;
  logic [ID_WIDTH-1:0]    w_grant;
  logic [ID_WIDTH-1:0]    w_base;

  logic                   r_tvalid;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [ID_WIDTH-1:0]    r_tid;

  // Unpack the interface array; interface elements need constant indices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    if ($bits(axis_sif[g].tdata) != TDATA_WIDTH) begin : g_width_err
      $fatal(1, "axis_rr_arbiter: requester %0d tdata width differs from output", g);
    end
    assign w_valid[g]         = axis_sif[g].tvalid;
    assign w_data[g]          = axis_sif[g].tdata;
    assign w_ready[g]         = w_take && (w_grant == ID_WIDTH'(g));
    assign axis_sif[g].tready = w_ready[g];
  end

`ifdef AXIS_RR_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [ID_WIDTH-1:0] r_ptr;

  assign w_base = r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_take) begin
      r_ptr <= (w_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
    end
  end
`endif

  // Circular search starting at the pointer; first valid requester wins.
  always_comb begin : p_grant
    int   idx;
    logic found;
    w_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(w_base) + k) % NUM_REQ;
      if (!found && w_valid[idx]) begin
        found   = 1'b1;
        w_grant = ID_WIDTH'(idx);
      end
    end
  end

  assign w_any      = |w_valid;
  assign w_out_free = !r_tvalid || axis_mif.tready;
  assign w_take     = w_out_free && w_any && !invalidate && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tid    <= '0;
    end else if (invalidate) begin
      r_tvalid <= 1'b0;
    end else if (w_out_free) begin
      r_tvalid <= w_any;
      if (w_any) begin
        r_tdata <= w_data[w_grant];
        r_tid   <= w_grant;
      end
    end
  end

  assign axis_mif.tvalid = r_tvalid;
  assign axis_mif.tdata  = r_tdata;
  assign m_tid           = r_tid;

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_arbiter.sv
// ============================================================================
// Module   : tb_axis_rr_arbiter
// Brief    : Directed and randomized self-checking bench for axis_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rr_arbiter;
  localparam int N = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         invalidate;
  logic         mready;
  logic [N-1:0] tv;
  logic [N-1:0] tr;
  logic [W-1:0] td [N];
  logic [1:0]   m_tid;

  always #5 clk = ~clk;

  axis_if #(.TDATA_WIDTH(W)) sif [N] ();
  axis_if #(.TDATA_WIDTH(W)) mif ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign sif[g].tvalid = tv[g];
    assign sif[g].tdata  = td[g];
    assign tr[g]         = sif[g].tready;
  end
  assign mif.tready = mready;

  axis_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .axis_sif   (sif),
    .axis_mif   (mif),
    .m_tid      (m_tid),
    .invalidate (invalidate)
  );

  // Reference model: output register contents and next-start index.
  int           ptr;
  bit           mv;
  logic [W-1:0] md;
  int           mt;
  bit   [N-1:0] acc;
  int           n_assert;
  int           n_fail;
  logic [W-1:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (tv[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Called just after a rising edge; checks handshakes, then the next output.
  task automatic tick();
    int g;
    bit free;
    bit take;
    #2;
    free = !mv || mready;
    g    = pick();
    take = free && (g >= 0) && !invalidate && !rst;
    for (int i = 0; i < N; i++) begin
      acc[i] = take && (g == i);
      chk($sformatf("tready%0d", i), 32'(tr[i]), 32'(acc[i]));
    end
    if (rst) begin
      mv = 0; md = '0; mt = 0; ptr = 0;
    end else if (invalidate) begin
      mv = 0;
    end else if (free) begin
      mv = (g >= 0);
      if (g >= 0) begin
        md = td[g];
        mt = g;
      end
    end
`ifndef AXIS_RR_ARB_FIXED_PRIO_EN
    if (take) ptr = (g + 1) % N;
`endif
    @(posedge clk);
    #1;
    chk("tvalid", 32'(mif.tvalid), 32'(mv));
    if (mv) begin
      chk("tdata", 32'(mif.tdata), 32'(md));
      chk("tid", 32'(m_tid), 32'(mt));
    end
  endtask

  // Replace accepted or idle beats; all=1 keeps every requester busy.
  task automatic refill(input bit all);
    for (int i = 0; i < N; i++) begin
      if (acc[i] || !tv[i]) begin
        tv[i] = all ? 1'b1 : 1'($urandom_range(0, 1));
        td[i] = W'($urandom);
      end
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    ptr = 0; mv = 0; md = '0; mt = 0; acc = '0;
    rst = 1'b1; invalidate = 1'b0; mready = 1'b1; tv = '1;
    for (int i = 0; i < N; i++) td[i] = W'($urandom);

    // Reset with every requester valid.
    tick();
    tick();
    chk("rst_tid", 32'(m_tid), 32'd0);
    chk("rst_tdata", 32'(mif.tdata), 32'd0);
    rst = 1'b0;

    // Fairness with all valid and downstream always ready.
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef AXIS_RR_ARB_FIXED_PRIO_EN
      chk("seq_tid", 32'(m_tid), 32'd0);
`else
      chk("seq_tid", 32'(m_tid), 32'(k % N));
`endif
      refill(1'b1);
    end

    // Drain, then req2 alone, then req0 and req2 together.
    tv = '0;
    tick();
    tv = 3'b100; td[2] = W'($urandom);
    tick();
    chk("only2_tid", 32'(m_tid), 32'd2);
    tv = 3'b101; td[0] = W'($urandom); td[2] = W'($urandom);
    tick();
    chk("wrap_tid0", 32'(m_tid), 32'd0);
    tv[0] = 1'b0;
    tick();
    chk("wrap_tid2", 32'(m_tid), 32'd2);

    // Downstream stall with a held beat.
    tv = 3'b111;
    for (int i = 0; i < N; i++) td[i] = W'($urandom);
    tick();
    mready = 1'b0;
    held   = mif.tdata;
    for (int k = 0; k < 5; k++) tick();
    chk("stall_hold", 32'(mif.tdata), 32'(held));
    mready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      refill(1'b1);
    end

    // Invalidate with a held beat and req1 valid.
    tv = '0; mready = 1'b0;
    tick();
    tv = 3'b010; td[1] = W'($urandom); invalidate = 1'b1;
    tick();
    chk("inv_tvalid", 32'(mif.tvalid), 32'd0);
    invalidate = 1'b0;
    tick();
    chk("inv_tid", 32'(m_tid), 32'd1);
    chk("inv_tvalid_after", 32'(mif.tvalid), 32'd1);
    tv[1] = 1'b0;

    // Randomized traffic including stalls, flushes and mid-transfer resets.
    for (int k = 0; k < 400; k++) begin
      refill(1'b0);
      mready     = ($urandom_range(0, 9) < 7);
      invalidate = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0; invalidate = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
